// File: rtl/float_to_pixel.sv
// Sequential IEEE-754 single to saturated unsigned integer / 8-bit pixel converter.
// Optional build macro ROUND_NEAREST_EN selects round-half-to-even; otherwise truncates.
module float_to_pixel (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_float,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic [7:0]  out_pixel,
  output logic [3:0]  out_flags
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;
  localparam int unsigned FW = 4;
  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;

  localparam int unsigned FLAG_NAN   = 3;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_NEG   = 1;
  localparam int unsigned FLAG_CLAMP = 0;

  // Exponent field values: 150 means e=23 (no shift), 159 means e=32, 125 means e=-2.
  localparam logic [EW-1:0] EXP_UNITY = EW'(150);
  localparam logic [EW-1:0] EXP_OVF   = EW'(159);
  localparam logic [EW-1:0] EXP_SMALL = EW'(125);
  localparam logic [EW-1:0] EXP_INF   = '1;
  localparam logic [DW-1:0] PIX_MAX   = DW'(255);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mant_q, mant_d;
  logic          guard_q, guard_d;
  logic          sticky_q, sticky_d;
  logic          left_q, left_d;
  logic [DW-1:0] fin_q, fin_d;
  logic          pend_q, pend_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_int_q, out_int_d;
  logic [FW-1:0] out_flags_q, out_flags_d;

  logic          sgn;
  logic [EW-1:0] exp_f;
  logic [MW-1:0] frac;
  logic          is_nan, is_neg, is_ovf, is_small, is_special;
  logic [DW-1:0] spec_int;
  logic [FW-1:0] spec_flags;
  logic [DW-1:0] round_val;

  assign sgn   = fin_q[DW-1];
  assign exp_f = fin_q[DW-2:MW];
  assign frac  = fin_q[MW-1:0];

  // Classify the captured float; nan beats negative beats overflow.
  always_comb begin
    is_nan     = (exp_f == EXP_INF) && (frac != '0);
    is_neg     = !is_nan && sgn && ((exp_f != '0) || (frac != '0));
    is_ovf     = !is_nan && !is_neg && ((exp_f == EXP_INF) || (exp_f >= EXP_OVF));
    is_small   = (exp_f <= EXP_SMALL);
    is_special = is_nan || is_neg || is_ovf || is_small || sgn;
    spec_int   = is_ovf ? '1 : '0;
    spec_flags = '0;
    spec_flags[FLAG_NAN]   = is_nan;
    spec_flags[FLAG_OVF]   = is_ovf;
    spec_flags[FLAG_NEG]   = is_neg;
    spec_flags[FLAG_CLAMP] = is_ovf;
  end

  // Rounding applied in ROUND using the accumulated guard/sticky bits.
`ifdef ROUND_NEAREST_EN
  logic round_up;
  always_comb begin
    round_up  = guard_q && (sticky_q || mant_q[0]);
    round_val = mant_q + DW'(round_up);
  end
`else
  always_comb begin
    round_val = mant_q;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mant_d      = mant_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    left_d      = left_q;
    fin_d       = fin_q;
    pend_d      = pend_q;
    out_int_d   = out_int_q;
    out_flags_d = out_flags_q;

    case (state_q)
      IDLE: begin
        // A captured float is decoded the cycle after it is accepted.
        if (pend_q) begin
          pend_d = 1'b0;
          if (is_special) begin
            out_int_d   = spec_int;
            out_flags_d = spec_flags;
            state_d     = DONE;
          end else begin
            mant_d   = DW'({1'b1, frac});
            guard_d  = 1'b0;
            sticky_d = 1'b0;
            left_d   = (exp_f > EXP_UNITY);
            cnt_d    = (exp_f > EXP_UNITY) ? CW'(exp_f - EXP_UNITY) : CW'(EXP_UNITY - exp_f);
            state_d  = (exp_f == EXP_UNITY) ? ROUND : SHIFT;
          end
        end else if (in_valid && in_ready_q) begin
          fin_d  = in_float;
          pend_d = 1'b1;
        end
      end
      SHIFT: begin
        if (left_q) begin
          mant_d = mant_q << 1;
        end else begin
          mant_d   = mant_q >> 1;
          guard_d  = mant_q[0];
          sticky_d = sticky_q | guard_q;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        out_int_d               = round_val;
        out_flags_d             = '0;
        out_flags_d[FLAG_CLAMP] = (round_val > PIX_MAX);
        state_d                 = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE) && !pend_d;
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mant_q      <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      left_q      <= 1'b0;
      fin_q       <= '0;
      pend_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_int_q   <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mant_q      <= mant_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      left_q      <= left_d;
      fin_q       <= fin_d;
      pend_q      <= pend_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_int_q   <= out_int_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_int   = out_int_q;
  assign out_flags = out_flags_q;
  assign out_pixel = (out_int_q > PIX_MAX) ? 8'hFF : out_int_q[7:0];

endmodule

// File: tb/tb_float_to_pixel.sv
// Self-checking bench for float_to_pixel: directed vector table, backpressure and
// reset-abort sequences, then random floats against an arithmetic reference model.
module tb_float_to_pixel;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_float;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_int;
  logic [7:0]  out_pixel;
  logic [3:0]  out_flags;

  int errors = 0;
  int checks = 0;

  float_to_pixel dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_float  (in_float),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int),
    .out_pixel (out_pixel),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f;
    logic [31:0] r;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

`ifdef ROUND_NEAREST_EN
  localparam logic [31:0] R_3P5  = 32'd4;
  localparam logic [31:0] R_0P75 = 32'd1;
  localparam logic [31:0] R_1P5  = 32'd2;
`else
  localparam logic [31:0] R_3P5  = 32'd3;
  localparam logic [31:0] R_0P75 = 32'd0;
  localparam logic [31:0] R_1P5  = 32'd1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact value M*2^(e-23), rounded by comparing the discarded remainder to one half.
  function automatic void ref_model(input logic [31:0] f, output logic [31:0] r,
                                    output logic [3:0] fl, output int lat);
    int          ex;
    int          e;
    int          k;
    logic [63:0] m;
    logic [63:0] q;
`ifdef ROUND_NEAREST_EN
    logic [63:0] rem;
    logic [63:0] half;
`endif
    ex  = int'(f[30:23]);
    e   = ex - 127;
    m   = {40'd0, 1'b1, f[22:0]};
    r   = 32'd0;
    fl  = 4'd0;
    lat = 1;
    if (ex == 255 && f[22:0] != 23'd0) begin
      fl[3] = 1'b1;
    end else if (f[31] && f[30:0] != 31'd0) begin
      fl[1] = 1'b1;
    end else if (f[31]) begin
      r = 32'd0;
    end else if (ex == 255 || e >= 32) begin
      r     = 32'hFFFF_FFFF;
      fl[2] = 1'b1;
    end else if (ex == 0 || e <= -2) begin
      r = 32'd0;
    end else begin
      if (e >= 23) begin
        lat = e - 23 + 2;
        q   = m << (e - 23);
      end else begin
        k   = 23 - e;
        lat = k + 2;
        q   = m >> k;
`ifdef ROUND_NEAREST_EN
        rem  = m - (q << k);
        half = 64'd1 << (k - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
`endif
      end
      r = q[31:0];
    end
    fl[0] = (r > 32'd255);
  endfunction

  // Send one float, measure latency, check the result, optionally stall, then release.
  task automatic do_vec(input string tag, input logic [31:0] f, input logic [31:0] er,
                        input logic [3:0] efl, input int elat, input int hold);
    int          lat;
    int          w;
    logic [31:0] epix;
    epix = (er > 32'd255) ? 32'd255 : er;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_float = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_float = $urandom;
    chk({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " out_int"}, out_int, er);
    chk({tag, " out_pixel"}, 32'(out_pixel), epix);
    chk({tag, " out_flags"}, 32'(out_flags), 32'(efl));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " stall valid/ready"}, 32'({out_valid, in_ready}), 32'd2);
      chk({tag, " stall out_int"}, out_int, er);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " release valid/ready"}, 32'({out_valid, in_ready}), 32'd1);
  endtask

  vec_t        vecs [18];
  logic [31:0] rf;
  logic [31:0] rr;
  logic [3:0]  rfl;
  int          rlat;
  int          w;

  initial begin
    vecs[0]  = '{32'h4020_0000, 32'd2,          4'h0, 24};
    vecs[1]  = '{32'h4060_0000, R_3P5,          4'h0, 24};
    vecs[2]  = '{32'h3F40_0000, R_0P75,         4'h0, 26};
    vecs[3]  = '{32'h437F_0000, 32'd255,        4'h0, 18};
    vecs[4]  = '{32'h4F00_0000, 32'h8000_0000,  4'h1, 10};
    vecs[5]  = '{32'h4F80_0000, 32'hFFFF_FFFF,  4'h5, 1};
    vecs[6]  = '{32'hC040_0000, 32'd0,          4'h2, 1};
    vecs[7]  = '{32'h7FC0_0000, 32'd0,          4'h8, 1};
    vecs[8]  = '{32'h3E99_1687, 32'd0,          4'h0, 1};
    vecs[9]  = '{32'h40A0_0000, 32'd5,          4'h0, 23};
    vecs[10] = '{32'h4B00_0000, 32'h0080_0000,  4'h1, 2};
    vecs[11] = '{32'h8000_0000, 32'd0,          4'h0, 1};
    vecs[12] = '{32'hFF80_0000, 32'd0,          4'h2, 1};
    vecs[13] = '{32'h7F80_0000, 32'hFFFF_FFFF,  4'h5, 1};
    vecs[14] = '{32'h0000_0001, 32'd0,          4'h0, 1};
    vecs[15] = '{32'h3F00_0000, 32'd0,          4'h0, 26};
    vecs[16] = '{32'h3FC0_0000, R_1P5,          4'h0, 25};
    vecs[17] = '{32'h4380_0000, 32'd256,        4'h1, 17};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_float  = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_int", out_int, 32'd0);
    chk("reset out_pixel", 32'(out_pixel), 32'd0);
    chk("reset out_flags", 32'(out_flags), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready after reset", 32'(in_ready), 32'd1);

    for (int i = 0; i < 18; i++) begin
      do_vec($sformatf("vec%0d", i), vecs[i].f, vecs[i].r, vecs[i].fl, vecs[i].lat, 0);
    end

    do_vec("backpressure", 32'h437F_0000, 32'd255, 4'h0, 18, 10);

    // Abort a conversion mid-SHIFT; the previous result must not survive reset.
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("abort in_ready before accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_float = 32'h437F_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort still busy", 32'({out_valid, in_ready}), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort out_int", out_int, 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("abort in_ready held", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort in_ready released", 32'(in_ready), 32'd1);
    do_vec("after abort", 32'h40A0_0000, 32'd5, 4'h0, 23, 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        rf = $urandom;
      end else begin
        rf[31]    = ($urandom_range(0, 15) == 0);
        rf[30:23] = 8'($urandom_range(123, 161));
        rf[22:0]  = 23'($urandom);
      end
      ref_model(rf, rr, rfl, rlat);
      do_vec($sformatf("rand%0d f=%08h", i, rf), rf, rr, rfl, rlat, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
